des_round_ctrl: RTL and testbench

//  Iterative DES sequencer. Owns IP/FP, L/R state and key schedule (PC1, rotations, PC2).

---
 rtl/des_round_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_des_round_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// Iterative DES sequencer: IP/FP, L/R state and key schedule around one shared,
// externally supplied f-function that is reused for all 16 rounds.
module des_round_ctrl #(
    parameter int F_LAT = 0
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic        i_Decrypt,
    input  logic [63:0] i_Data,
    input  logic [63:0] i_Key,
    output logic [31:0] o_F_R,
    output logic [47:0] o_F_Key,
    input  logic [31:0] i_F_Data,
    output logic [3:0]  o_Round,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [63:0] o_Data
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    localparam int CW = (F_LAT > 0) ? $clog2(F_LAT + 1) : 1;

    // Permutation tables use DES numbering: entry i names the source bit (1 = MSB).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
        return y;
    endfunction

    // Decrypt walks the schedule backwards: no shift for the first round, since
    // the PC1 value already equals C16/D16.
    function automatic logic [1:0] shift_amt(input logic [3:0] rnd, input logic dec);
        logic single;
        single = (rnd == 4'd0) || (rnd == 4'd1) || (rnd == 4'd8) || (rnd == 4'd15);
        if (dec && rnd == 4'd0) return 2'd0;
        return single ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic dec,
                                          input logic [1:0] n);
        logic [27:0] y;
        case ({dec, n})
            3'b001:  y = {x[26:0], x[27]};
            3'b010:  y = {x[25:0], x[27:26]};
            3'b101:  y = {x[0], x[27:1]};
            3'b110:  y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    state_t         state_q;
    logic [31:0]    l_q, r_q;
    logic [27:0]    c_q, d_q;
    logic           mode_q;
    logic [3:0]     round_q;
    logic [CW-1:0]  cnt_q;
    logic           ready_q, valid_q;
    logic [63:0]    data_q;

    logic [1:0]     shamt_d;
    logic [27:0]    c_rot_d, d_rot_d;
    logic [31:0]    r_next_d;
    logic           step_d;

    always_comb begin
        shamt_d  = shift_amt(round_q, mode_q);
        c_rot_d  = rot28(c_q, mode_q, shamt_d);
        d_rot_d  = rot28(d_q, mode_q, shamt_d);
        r_next_d = l_q ^ i_F_Data;
        step_d   = (cnt_q == CW'(F_LAT));
    end

    assign o_F_Key = perm_pc2({c_rot_d, d_rot_d});
    assign o_F_R   = r_q;
    assign o_Round = round_q;
    assign o_Ready = ready_q;
    assign o_Valid = valid_q;
    assign o_Data  = data_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            round_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_Valid && ready_q) begin
                        {l_q, r_q} <= perm_ip(i_Data);
                        {c_q, d_q} <= perm_pc1(i_Key);
                        mode_q     <= i_Decrypt;
                        round_q    <= '0;
                        cnt_q      <= '0;
                        ready_q    <= 1'b0;
                        state_q    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (step_d) begin
                        l_q     <= r_q;
                        r_q     <= r_next_d;
                        c_q     <= c_rot_d;
                        d_q     <= d_rot_d;
                        cnt_q   <= '0;
                        round_q <= round_q + 4'd1;
                        // Final round: output is FP of the swapped halves {R16, L16}.
                        if (round_q == 4'd15) begin
                            data_q  <= perm_fp({r_next_d, r_q});
                            valid_q <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_Ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: supplies a DES f-function (combinational and 2-cycle
// pipelined) and scoreboards results against published DES vectors.
module tb_des_round_ctrl;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam logic [63:0] CZ = 64'h8CA64DE9C1B123A7;

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int S_T [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        logic [5:0]  b;
        int          idx;
        e = '0; s = '0; p = '0;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = e[47 - 6*j -: 6];
            idx = j * 64 + int'({b[5], b[0]}) * 16 + int'(b[4:1]);
            s[31 - 4*j -: 4] = 4'(S_T[9'(idx)]);
        end
        for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
        return p;
    endfunction

    logic        clk, rst;
    logic        vld0, vld2, dec, rdy_in;
    logic [63:0] din, key;
    logic        rdy0, ovld0, rdy2, ovld2;
    logic [31:0] fr0, fr2, fd0, fd2;
    logic [47:0] fk0, fk2;
    logic [3:0]  rnd0, rnd2;
    logic [63:0] dout0, dout2;
    logic [31:0] fpipe_a, fpipe_b;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [63:0] exp_q[$];

    des_round_ctrl #(.F_LAT(0)) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(vld0), .o_Ready(rdy0), .i_Decrypt(dec),
        .i_Data(din), .i_Key(key), .o_F_R(fr0), .o_F_Key(fk0), .i_F_Data(fd0),
        .o_Round(rnd0), .o_Valid(ovld0), .i_Ready(rdy_in), .o_Data(dout0));

    des_round_ctrl #(.F_LAT(2)) dut2 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(vld2), .o_Ready(rdy2), .i_Decrypt(dec),
        .i_Data(din), .i_Key(key), .o_F_R(fr2), .o_F_Key(fk2), .i_F_Data(fd2),
        .o_Round(rnd2), .o_Valid(ovld2), .i_Ready(rdy_in), .o_Data(dout2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fd0 = des_f(fr0, fk0);
    always @(posedge clk) begin
        fpipe_a <= des_f(fr2, fk2);
        fpipe_b <= fpipe_a;
    end
    assign fd2 = fpipe_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        din = {$urandom, $urandom};
        key = {$urandom, $urandom};
        dec = ~dec;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (rdy0 !== 1'b1) $display("FAIL reset_ready0: got %b want 1", rdy0); else n_pass++;
        n_checks++; if (ovld0 !== 1'b0) $display("FAIL reset_valid0: got %b want 0", ovld0); else n_pass++;
        n_checks++; if (dout0 !== 64'h0) $display("FAIL reset_data0: got %h want 0", dout0); else n_pass++;
        n_checks++; if (rnd0 !== 4'd0) $display("FAIL reset_round0: got %0d want 0", rnd0); else n_pass++;
        n_checks++; if (fr0 !== 32'h0) $display("FAIL reset_fr0: got %h want 0", fr0); else n_pass++;
        n_checks++; if ({rdy2, ovld2, rnd2} !== 6'b100000) $display("FAIL reset_ctl2: got %b want 100000", {rdy2, ovld2, rnd2}); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic run_block(input string nm, input logic d, input logic [63:0] k,
                             input logic [63:0] data, input logic [63:0] expv);
        int n;
        logic [63:0] e;
        exp_q.push_back(expv);
        dec = d; key = k; din = data; vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        scramble();
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL %s_busy: ready got %b want 0", nm, rdy0); else n_pass++;
        n = 0;
        while (ovld0 !== 1'b1 && n < 100) begin tick(); n++; end
        n_checks++; if (n != 16) $display("FAIL %s_latency: got %0d want 16 cycles", nm, n); else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_checks++; if (dout0 !== e) $display("FAIL %s_data: got %h want %h", nm, dout0, e); else n_pass++;
        tick();
        n_checks++; if ({rdy0, ovld0} !== 2'b10) $display("FAIL %s_handoff: ready/valid got %b want 10", nm, {rdy0, ovld0}); else n_pass++;
    endtask

    task automatic test_flat2();
        int n, bad_rnd, bad_hold;
        logic [31:0] r_start;
        logic [47:0] k_start;
        logic [63:0] e;
        exp_q.push_back(C1);
        dec = 1'b0; key = K1; din = P1; vld2 = 1'b1;
        tick();
        vld2 = 1'b0;
        scramble();
        n = 0; bad_rnd = 0; bad_hold = 0; r_start = '0; k_start = '0;
        while (ovld2 !== 1'b1 && n < 200) begin
            if (n < 3) begin
                n_checks++; if (fk2 !== 48'h1B02EFFC7072) $display("FAIL flat2_k1_c%0d: got %h want 1b02effc7072", n, fk2); else n_pass++;
            end
            if (rnd2 !== 4'(n / 3)) bad_rnd++;
            if (n % 3 == 0) begin
                r_start = fr2; k_start = fk2;
            end else if (fr2 !== r_start || fk2 !== k_start) begin
                bad_hold++;
            end
            tick(); n++;
        end
        n_checks++; if (n != 48) $display("FAIL flat2_latency: got %0d want 48 cycles", n); else n_pass++;
        n_checks++; if (bad_rnd != 0) $display("FAIL flat2_round_seq: %0d cycles off, want 0", bad_rnd); else n_pass++;
        n_checks++; if (bad_hold != 0) $display("FAIL flat2_hold: %0d cycles changed, want 0", bad_hold); else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_checks++; if (dout2 !== e) $display("FAIL flat2_data: got %h want %h", dout2, e); else n_pass++;
        tick();
        n_checks++; if ({rdy2, ovld2} !== 2'b10) $display("FAIL flat2_handoff: got %b want 10", {rdy2, ovld2}); else n_pass++;
    endtask

    task automatic test_stall();
        int n, bad;
        logic [63:0] e;
        exp_q.push_back(C1);
        dec = 1'b0; key = K1; din = P1; vld0 = 1'b1;
        tick();
        vld0 = 1'b0; rdy_in = 1'b0;
        repeat (5) tick();
        dec = 1'b1; key = '0; din = '0; vld0 = 1'b1;
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL stall_busy_ready: got %b want 0", rdy0); else n_pass++;
        tick();
        vld0 = 1'b0;
        n = 0;
        while (ovld0 !== 1'b1 && n < 100) begin tick(); n++; end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_checks++; if (dout0 !== e) $display("FAIL stall_data: got %h want %h", dout0, e); else n_pass++;
        bad = 0;
        repeat (10) begin
            tick();
            if (ovld0 !== 1'b1 || dout0 !== e) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL stall_hold: %0d cycles changed, want 0", bad); else n_pass++;
        exp_q.push_back(P1);
        rdy_in = 1'b1; vld0 = 1'b1; dec = 1'b1; key = K1; din = C1;
        tick();
        n_checks++; if ({rdy0, ovld0} !== 2'b10) $display("FAIL stall_handoff: got %b want 10", {rdy0, ovld0}); else n_pass++;
        tick();
        vld0 = 1'b0;
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL stall_accept_next: ready got %b want 0", rdy0); else n_pass++;
        n = 0;
        while (ovld0 !== 1'b1 && n < 100) begin tick(); n++; end
        n_checks++; if (n != 16) $display("FAIL stall_relatency: got %0d want 16", n); else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_checks++; if (dout0 !== e) $display("FAIL stall_dec_data: got %h want %h", dout0, e); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int n, bad;
        dec = 1'b0; key = K1; din = P1; vld0 = 1'b1;
        tick();
        vld0 = 1'b0;
        n = 0;
        while (rnd0 !== 4'd7 && n < 40) begin tick(); n++; end
        n_checks++; if (rnd0 !== 4'd7) $display("FAIL rstmid_reach7: round got %0d want 7", rnd0); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({rdy0, ovld0, rnd0} !== 6'b100000) $display("FAIL rstmid_ctl: got %b want 100000", {rdy0, ovld0, rnd0}); else n_pass++;
        n_checks++; if (dout0 !== 64'h0) $display("FAIL rstmid_data: got %h want 0", dout0); else n_pass++;
        bad = 0;
        repeat (20) begin
            tick();
            if (ovld0 !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL rstmid_no_valid: %0d cycles valid, want 0", bad); else n_pass++;
        run_block("rerun", 1'b0, K1, P1, C1);
    endtask

    task automatic test_back_to_back();
        int n, c1, c2;
        logic [63:0] e;
        exp_q.push_back(C1);
        dec = 1'b0; key = K1; din = P1; vld0 = 1'b1;
        tick();
        exp_q.push_back(P1);
        dec = 1'b1; din = C1;
        n = 0;
        while (ovld0 !== 1'b1 && n < 100) begin tick(); n++; end
        c1 = cyc;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_checks++; if (dout0 !== e) $display("FAIL b2b_first: got %h want %h", dout0, e); else n_pass++;
        tick();
        n_checks++; if (rdy0 !== 1'b1) $display("FAIL b2b_idle_gap: ready got %b want 1", rdy0); else n_pass++;
        tick();
        vld0 = 1'b0;
        n = 0;
        while (ovld0 !== 1'b1 && n < 100) begin tick(); n++; end
        c2 = cyc;
        n_checks++; if (c2 - c1 != 18) $display("FAIL b2b_spacing: got %0d want 18 cycles", c2 - c1); else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        n_checks++; if (dout0 !== e) $display("FAIL b2b_second: got %h want %h", dout0, e); else n_pass++;
        tick();
    endtask

    initial begin
        rst = 1'b1; vld0 = 1'b0; vld2 = 1'b0; dec = 1'b0; rdy_in = 1'b1;
        din = '0; key = '0;
        test_reset();
        run_block("enc1", 1'b0, K1, P1, C1);
        run_block("dec1", 1'b1, K1, C1, P1);
        run_block("enc2", 1'b0, K2, P2, C2);
        run_block("dec2", 1'b1, K2, C2, P2);
        run_block("encz", 1'b0, 64'h0, 64'h0, CZ);
        test_flat2();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
